// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the low-power 16-bit ALU and its result buffer.
//   - ALU_W         : ALU datapath width.
//   - OP_ADD..OP_MUL: 3-bit alu_op encodings.
//   - result_core_t : per-result payload {data, op, zero, carry}. The issue tag
//                     is concatenated on top of this in the buffer, because its
//                     width is a parameter of the buffer and cannot be fixed here.
//   - carryApplies  : true for the ops whose carry flag is meaningful.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef struct packed {
      logic [ALU_W-1:0] data;
      logic [2:0]       op;
      logic             zero;
      logic             carry;
   } result_core_t;

   // Only ADD and SUB produce a carry the consumer may act on; every other op
   // leaves alu_carry holding stale or meaningless state.
   function automatic logic carryApplies(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// Generic DEPTH x WIDTH synchronous FIFO with an explicit occupancy counter, so
// full and empty never depend on pointer comparison.
// Ports:
//   gated_clk / rst_n : clock, asynchronous active-low reset
//   push_i, wdata_i   : write request and data; ignored when full without a pop
//   pop_i             : remove head; ignored when empty
//   flush_i           : synchronous empty, wins over push and pop
//   rdata_o           : head entry, forced to zero while empty
//   count_o           : occupancy 0..DEPTH
//   full_o / empty_o  : occupancy flags
// -----------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     gated_clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

   // Decide what actually happens this edge. A push into a full FIFO only
   // succeeds when the head leaves at the same time. Pointers wrap naturally
   // because DEPTH is a power of two.
   always_comb begin
      doPop   = pop_i & ~empty_o & ~flush_i;
      doPush  = push_i & ~flush_i & (~full_o | doPop);
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
         end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Pointer and count state; reset leaves the FIFO empty immediately.
   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the read side is masked to zero while empty.
   always_ff @(posedge gated_clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Sits behind the registered ALU in the gated clock domain. Remembers the
// tag/opcode of each issued op for one cycle, joins it with the ALU result
// when that result appears, recomputes the zero flag locally (the ALU's own
// flag is a cycle late) and queues the entry toward writeback.
// Ports:
//   gated_clk / rst_n          : clock, asynchronous active-low reset
//   issue_valid/tag/op         : op presented to the ALU this cycle
//   alu_result / alu_carry     : registered ALU outputs for last cycle's op
//   flush                      : discard pending and queued entries
//   out_ready / out_valid      : handshake with the writeback consumer
//   out_data/tag/op/zero/carry : head entry, all zero while empty
//   fifo_count                 : occupancy
//   overflow / drop_count      : sticky drop flag and saturating drop count
//   busy                       : work in flight; upstream keeps the clock on
// -----------------------------------------------------------------------------
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                   gated_clk,
   input  logic                   rst_n,
   input  logic                   issue_valid,
   input  logic [TAG_W-1:0]       issue_tag,
   input  logic [2:0]             issue_op,
   input  logic [ALU_W-1:0]       alu_result,
   input  logic                   alu_carry,
   input  logic                   flush,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [ALU_W-1:0]       out_data,
   output logic [TAG_W-1:0]       out_tag,
   output logic [2:0]             out_op,
   output logic                   out_zero,
   output logic                   out_carry,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_count,
   output logic                   busy
);

   localparam int ENTRY_W = TAG_W + $bits(result_core_t);

   logic               pendValid_q, pendValid_d;
   logic [TAG_W-1:0]   pendTag_q, pendTag_d;
   logic [2:0]         pendOp_q, pendOp_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   dropCount_q, dropCount_d;

   result_core_t       pushCore;
   result_core_t       headCore;
   logic [TAG_W-1:0]   headTag;
   logic [ENTRY_W-1:0] fifoWdata;
   logic [ENTRY_W-1:0] fifoRdata;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               push;
   logic               pop;
   logic               drop;

   // The ALU registers its result on the same edge we capture the tag, so the
   // tag/op must be held one cycle to line up with alu_result. A flush also
   // swallows whatever is being issued on that edge.
   always_comb begin
      pendValid_d = issue_valid & ~flush;
      pendTag_d   = issue_tag;
      pendOp_d    = issue_op;
   end

   // Build the entry from the matured ALU result. The drop decision only
   // looks at occupancy and the simultaneous pop; a full FIFO with the head
   // leaving still accepts the new entry.
   always_comb begin
      pushCore.data  = alu_result;
      pushCore.op    = pendOp_q;
      pushCore.zero  = (alu_result == '0);
      pushCore.carry = carryApplies(pendOp_q) & alu_carry;
      fifoWdata      = {pendTag_q, pushCore};
      push           = pendValid_q & ~flush;
      pop            = out_valid & out_ready;
      drop           = push & fifoFull & ~pop;
   end

   // Overflow is cleared by flush so software can observe fresh drops, but
   // the drop counter is a lifetime statistic and only saturates.
   always_comb begin
      overflow_d  = overflow_q;
      dropCount_d = dropCount_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
      if (drop && (dropCount_q != {CNT_W{1'b1}})) begin
         dropCount_d = dropCount_q + CNT_W'(1);
      end
   end

   // All buffer-level state; async reset discards everything at once.
   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         pendValid_q <= 1'b0;
         pendTag_q   <= '0;
         pendOp_q    <= '0;
         overflow_q  <= 1'b0;
         dropCount_q <= '0;
      end else begin
         pendValid_q <= pendValid_d;
         pendTag_q   <= pendTag_d;
         pendOp_q    <= pendOp_d;
         overflow_q  <= overflow_d;
         dropCount_q <= dropCount_d;
      end
   end

   alu_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) uFifo (
      .gated_clk (gated_clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .pop_i     (pop),
      .flush_i   (flush),
      .wdata_i   (fifoWdata),
      .rdata_o   (fifoRdata),
      .count_o   (fifo_count),
      .full_o    (fifoFull),
      .empty_o   (fifoEmpty)
   );

   // Head fields come straight from the FIFO, which already zeroes them when
   // empty, so no extra masking is needed here.
   assign {headTag, headCore} = fifoRdata;
   assign out_valid  = ~fifoEmpty;
   assign out_data   = headCore.data;
   assign out_tag    = headTag;
   assign out_op     = headCore.op;
   assign out_zero   = headCore.zero;
   assign out_carry  = headCore.carry;
   assign overflow   = overflow_q;
   assign drop_count = dropCount_q;
   assign busy       = pendValid_q | out_valid;

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed bench for alu_result_buffer. Stimulus pushes hand-computed expected
// entries into a queue; an independent monitor pops and compares whenever the
// consumer handshake completes. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CNT_W = 8;

   logic                   gated_clk = 1'b0;
   logic                   rst_n;
   logic                   issue_valid;
   logic [TAG_W-1:0]       issue_tag;
   logic [2:0]             issue_op;
   logic [ALU_W-1:0]       alu_result;
   logic                   alu_carry;
   logic                   flush;
   logic                   out_ready;
   logic                   out_valid;
   logic [ALU_W-1:0]       out_data;
   logic [TAG_W-1:0]       out_tag;
   logic [2:0]             out_op;
   logic                   out_zero;
   logic                   out_carry;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   overflow;
   logic [CNT_W-1:0]       drop_count;
   logic                   busy;

   int checks = 0;
   int failures = 0;
   logic [24:0] expQ[$];

   alu_result_buffer #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W),
      .CNT_W (CNT_W)
   ) dut (
      .gated_clk   (gated_clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_tag   (issue_tag),
      .issue_op    (issue_op),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry),
      .flush       (flush),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .out_op      (out_op),
      .out_zero    (out_zero),
      .out_carry   (out_carry),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .busy        (busy)
   );

   // Free-running clock; gating is upstream's business and not modelled here.
   always #5 gated_clk = ~gated_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One cycle of stimulus: drive everything, let one rising edge happen, and
   // return 1 time unit later so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic iv, input logic [TAG_W-1:0] tag,
                                input logic [2:0] op, input logic [15:0] res,
                                input logic c, input logic fl);
      issue_valid = iv;
      issue_tag   = tag;
      issue_op    = op;
      alu_result  = res;
      alu_carry   = c;
      flush       = fl;
      @(posedge gated_clk);
      #1;
   endtask

   task automatic expectEntry(input logic [15:0] data, input logic [TAG_W-1:0] tag,
                              input logic [2:0] op, input logic zero, input logic carry);
      expQ.push_back({data, tag, op, zero, carry});
   endtask

   // Idle with out_ready held until the FIFO empties, bounded by a cycle budget.
   task automatic drainQueue(input string name);
      for (int k = 0; k < 20 && out_valid; k++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
      end
      checkOutput({name, "_drained"}, out_valid, 1'b0);
      checkOutput({name, "_scoreboardEmpty"}, expQ.size(), 0);
   endtask

   // Monitor: a head that will be accepted on the coming edge is compared
   // against the oldest expected entry.
   always @(negedge gated_clk) begin
      logic [24:0] expEntry;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedPop: got tag 0x%0h data 0x%0h, expected no entry",
                     out_tag, out_data);
         end else begin
            expEntry = expQ.pop_front();
            checkOutput("headEntry", {7'b0, out_data, out_tag, out_op, out_zero, out_carry},
                        {7'b0, expEntry});
         end
      end
   end

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got no completion, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n       = 1'b0;
      issue_valid = 1'b0;
      issue_tag   = '0;
      issue_op    = '0;
      alu_result  = '0;
      alu_carry   = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b0;
      #12;
      checkOutput("rst_outValid",  out_valid, 0);
      checkOutput("rst_fifoCount", fifo_count, 0);
      checkOutput("rst_outData",   out_data, 0);
      checkOutput("rst_outTag",    out_tag, 0);
      checkOutput("rst_outFlags",  {out_op, out_zero, out_carry}, 0);
      checkOutput("rst_overflow",  overflow, 0);
      checkOutput("rst_dropCount", drop_count, 0);
      checkOutput("rst_busy",      busy, 0);
      @(negedge gated_clk);
      rst_n = 1'b1;
      @(posedge gated_clk);
      #1;

      $display("[TB] single ADD, 0xFFFF+0x0001");
      out_ready = 1'b1;
      expectEntry(16'h0000, 4'd3, OP_ADD, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'd3, OP_ADD, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("add_latencyEdge1", out_valid, 0);
      checkOutput("add_busyPending", busy, 1);
      applyStimulus(1'b0, '0, '0, 16'h0000, 1'b1, 1'b0);
      checkOutput("add_latencyEdge2", out_valid, 1);
      checkOutput("add_count", fifo_count, 1);
      drainQueue("add");

      $display("[TB] carry masking on AND, carry kept on SUB");
      expectEntry(16'h00F0, 4'd5, OP_AND, 1'b0, 1'b0);
      expectEntry(16'h1234, 4'd6, OP_SUB, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd5, OP_AND, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd6, OP_SUB, 16'h00F0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 16'h1234, 1'b1, 1'b0);
      drainQueue("mask");

      $display("[TB] back-to-back fill with consumer stalled");
      out_ready = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         logic [15:0] res;
         res = 16'h1000 + 16'(i) - 16'd1;
         if (i >= 1 && i <= 4) begin
            expectEntry(res, 4'(i - 1), OP_OR, 1'b0, 1'b0);
         end
         applyStimulus(i < 6, 4'(i), OP_OR, res, 1'b1, 1'b0);
      end
      checkOutput("fill_count",     fifo_count, 4);
      checkOutput("fill_overflow",  overflow, 1);
      checkOutput("fill_dropCount", drop_count, 2);
      checkOutput("fill_busy",      busy, 1);
      checkOutput("fill_headTag",   out_tag, 0);
      out_ready = 1'b1;
      drainQueue("fill");
      checkOutput("fill_overflowSticky", overflow, 1);

      $display("[TB] full with concurrent push and pop");
      out_ready = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         logic [15:0] res;
         int          prevTag;
         prevTag = 8 + i - 1;
         res     = 16'h2000 + 16'(prevTag);
         if (i >= 1) begin
            expectEntry(res, 4'(prevTag), OP_ADD, 1'b0, prevTag[0]);
         end
         if (i == 5) begin
            out_ready = 1'b1;
         end
         applyStimulus(i < 8, 4'(8 + i), OP_ADD, res, prevTag[0], 1'b0);
         if (i >= 5) begin
            checkOutput($sformatf("stream_count%0d", i), fifo_count, 4);
         end
      end
      checkOutput("stream_dropCount", drop_count, 2);
      drainQueue("stream");

      $display("[TB] flush with entries queued and one pending");
      out_ready = 1'b0;
      for (int i = 0; i <= 3; i++) begin
         applyStimulus(1'b1, 4'(i + 1), OP_XOR, 16'h3000 + 16'(i), 1'b0, 1'b0);
      end
      checkOutput("flush_countBefore", fifo_count, 3);
      checkOutput("flush_overflowBefore", overflow, 1);
      applyStimulus(1'b1, 4'd5, OP_XOR, 16'h3003, 1'b0, 1'b1);
      checkOutput("flush_count",     fifo_count, 0);
      checkOutput("flush_outValid",  out_valid, 0);
      checkOutput("flush_busy",      busy, 0);
      checkOutput("flush_overflow",  overflow, 0);
      checkOutput("flush_dropCount", drop_count, 2);
      applyStimulus(1'b0, '0, '0, 16'h5555, 1'b0, 1'b0);
      checkOutput("flush_issueIgnored", fifo_count, 0);

      $display("[TB] asynchronous reset mid-stream");
      applyStimulus(1'b1, 4'd7, OP_ADD, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd8, OP_ADD, 16'h0007, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 16'h0008, 1'b0, 1'b0);
      checkOutput("arst_countBefore", fifo_count, 2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_outValid",  out_valid, 0);
      checkOutput("arst_fifoCount", fifo_count, 0);
      checkOutput("arst_outData",   {out_data, out_tag, out_op, out_zero, out_carry}, 0);
      checkOutput("arst_dropCount", drop_count, 0);
      checkOutput("arst_busy",      busy, 0);
      @(negedge gated_clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
      checkOutput("final_scoreboardEmpty", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
